queue_enq_arbiter: RTL and testbench
====================================

Name: queue_enq_arbiter

Overview:
Round-robin, burst-locking arbiter that shares the enqueue port of one 128-bit synchronous queue between NUM_REQ producers. A granted producer keeps the queue until it signals last or hits MAX_BURST. New bursts are throttled on the queue's occupancy count against a programmable high watermark. Sits directly in front of the 2-port-memory sync queue in the VTA load/store path; the dequeue side is untouched.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_W, 128, beat width; equals queue data width
CNT_W, 8, queue occupancy count width
MAX_BURST, 16, beats after which a burst is force-released (>=1)

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-producer beat valid
req_ready  out  NUM_REQ  per-producer beat accept
req_bits  in  NUM_REQ*DATA_W  producer i data at slice [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  final beat of the producer's burst
q_enq_valid  out  1  to queue enq valid
q_enq_ready  in  1  from queue enq ready
q_enq_bits  out  DATA_W  to queue enq bits
q_count  in  CNT_W  queue occupancy
cfg_high_wm  in  CNT_W  no new grant while q_count >= cfg_high_wm; 0 disables throttle
grant_id  out  clog2(NUM_REQ)  current/last granted producer
busy  out  1  1 while a burst is locked
err_overrun  out  NUM_REQ  sticky: producer force-released by MAX_BURST
err_clear  in  1  clears err_overrun

Behaviour:
- Reset (reset=0, async): state IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0, err_overrun=0, req_ready=0, q_enq_valid=0, q_enq_bits=0. Reset mid-burst abandons the burst immediately; queue contents are not touched.
- FSM states IDLE, BURST.
- IDLE: req_ready=0, q_enq_valid=0. Eligible if any req_valid and (cfg_high_wm==0 or q_count<cfg_high_wm). Winner = first set req_valid searching rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ-1 to 0. Next cycle: grant_id=winner, busy=1, beat_cnt=0, state BURST. Result: one-cycle arbitration bubble between bursts.
- BURST, g=grant_id: q_enq_valid=req_valid[g]; q_enq_bits=req_bits slice g; req_ready[g]=q_enq_ready; all other req_ready=0. These paths are combinational; there is no data register.
- Beat = req_valid[g] & q_enq_ready.
- On a beat: beat_cnt+1.
- If req_last[g], or beat_cnt==MAX_BURST-1: state IDLE, busy=0, rr_ptr=(g+1) wrapped.
- Forced release (count hit, last=0): err_overrun[g] is set.
- Producer deasserting valid mid-burst: lock held, no timeout, outputs idle until valid returns.
- Watermark only gates new grants; it never interrupts a locked burst.
- q_enq_ready low: hold; beat_cnt unchanged.
- err_clear clears all err_overrun bits. A set in the same cycle wins for that bit.
- grant_id holds its value in IDLE.
- q_enq_bits=0 when not in BURST.
- beat_cnt width is clog2(MAX_BURST+1).

Decomposition:
- Shared package vta_queue_pkg: DATA_W, CNT_W constants; arb_state_e enum {IDLE, BURST}.
- One natural sub-module: rr_pick, a combinational rotating-priority picker (req vector, rr_ptr) -> (any, idx). It is reused by later dequeue-side schedulers.

Test Plan:
- Single producer burst: req0 sends 3 beats, last on beat 3, q_enq_ready=1 -> grant_id=0 one cycle after valid; 3 beats reach the queue in order; busy drops after beat 3; err_overrun=0.
- Fairness: all 4 req_valid constant, 1-beat bursts -> grants cycle 0,1,2,3,0 with one idle cycle between bursts.
- Watermark: cfg_high_wm=8. Case q_count=8 with req1 valid -> no grant. Case q_count=7 -> grant in next cycle. Case q_count reaches 8 mid-burst -> burst completes.
- Overrun: MAX_BURST=16, req2 streams 20 beats with no last -> release after beat 16; err_overrun[2]=1; rr_ptr=3. Assert err_clear -> bit clears.
- Backpressure/stall: q_enq_ready toggles 1,0,0,1 and req_valid drops mid-burst -> no beat lost or duplicated; req_ready for non-granted producers stays 0.
- Async reset mid-burst: reset=0 during beat 2 -> all outputs 0 immediately. After release, arbitration restarts at rr_ptr=0.

Source files
------------

// File: rtl/vta_queue_pkg.sv
// Shared definitions for the VTA load/store queue path.
//   DATA_W      : beat width of the 128-bit synchronous queue
//   CNT_W       : width of the queue occupancy count
//   arb_state_e : enqueue arbiter FSM states
package vta_queue_pkg;

  localparam int DATA_W = 128;
  localparam int CNT_W  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage : vta_queue_pkg

// File: rtl/queue_enq_arbiter_if.sv
// Bundle of the producer-side beat handshakes and the queue enqueue port.
//   req_valid/req_ready/req_bits/req_last : NUM_REQ producer channels,
//                                           producer i data at [i*DATA_W +: DATA_W]
//   q_enq_valid/q_enq_ready/q_enq_bits    : single queue enqueue channel
//   q_count                               : queue occupancy
// Modports:
//   slave  : the arbiter's view (consumes producers, drives the queue)
//   master : the surrounding environment (producers plus queue)
interface queue_enq_arbiter_if
  import vta_queue_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = vta_queue_pkg::DATA_W,
  parameter int CNT_W   = vta_queue_pkg::CNT_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_bits;
  logic [NUM_REQ-1:0]        req_last;
  logic                      q_enq_valid;
  logic                      q_enq_ready;
  logic [DATA_W-1:0]         q_enq_bits;
  logic [CNT_W-1:0]          q_count;

  modport slave (
    input  req_valid, req_bits, req_last, q_enq_ready, q_count,
    output req_ready, q_enq_valid, q_enq_bits
  );

  modport master (
    output req_valid, req_bits, req_last, q_enq_ready, q_count,
    input  req_ready, q_enq_valid, q_enq_bits
  );

endinterface : queue_enq_arbiter_if

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   req_i : request vector
//   ptr_i : highest-priority position this cycle (must be < N)
//   any_o : at least one request is set
//   idx_o : first set request searching ptr_i, ptr_i+1, ... wrapping to 0
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int off = 0; off < N; off++) begin
      int cand;
      cand = int'(ptr_i) + off;
      if (cand >= N) cand = cand - N;
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(cand);
      end
    end
  end

endmodule : rr_pick

// File: rtl/queue_enq_arbiter.sv
// Round-robin, burst-locking arbiter in front of the queue enqueue port.
// A granted producer owns the queue until it flags last or has moved
// MAX_BURST beats; new bursts are held off while the queue is at or above
// the high watermark.
//   clock, reset  : clock, asynchronous active-low reset
//   bus           : producer channels and queue enqueue port (slave modport)
//   cfg_high_wm   : no new grant while q_count >= cfg_high_wm (0 = no throttle)
//   grant_id      : current / most recent granted producer
//   busy          : a burst is locked
//   err_overrun   : sticky, producer was force-released at MAX_BURST
//   err_clear     : clears err_overrun (a same-cycle set wins)
module queue_enq_arbiter
  import vta_queue_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = vta_queue_pkg::DATA_W,
  parameter int CNT_W     = vta_queue_pkg::CNT_W,
  parameter int MAX_BURST = 16,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  queue_enq_arbiter_if.slave     bus,
  input  logic [CNT_W-1:0]       cfg_high_wm,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   busy,
  output logic [NUM_REQ-1:0]     err_overrun,
  input  logic                   err_clear
);

  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]  err_q, err_d;

  logic                pick_any;
  logic [IDX_W-1:0]    pick_idx;
  logic                wm_ok;
  logic                beat;
  logic                cnt_hit;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign wm_ok   = (cfg_high_wm == '0) || (bus.q_count < cfg_high_wm);
  assign beat    = (state_q == BURST) && bus.req_valid[grant_q] && bus.q_enq_ready;
  assign cnt_hit = (beat_cnt_q == BCNT_W'(MAX_BURST - 1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    // Clear first so that a force-release below overrides it for its bit.
    err_d      = err_clear ? '0 : err_q;

    unique case (state_q)
      IDLE: begin
        if (pick_any && wm_ok) begin
          state_d    = BURST;
          grant_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          if (bus.req_last[grant_q] || cnt_hit) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
            if (!bus.req_last[grant_q]) err_d[grant_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  // Data and handshakes pass straight through to the granted producer; there
  // is no data register, so reset forces these to zero via state_q alone.
  always_comb begin
    bus.req_ready   = '0;
    bus.q_enq_valid = 1'b0;
    bus.q_enq_bits  = '0;
    if (state_q == BURST) begin
      bus.req_ready[grant_q] = bus.q_enq_ready;
      bus.q_enq_valid        = bus.req_valid[grant_q];
      bus.q_enq_bits         = bus.req_bits[grant_q*DATA_W +: DATA_W];
    end
  end

  assign grant_id    = grant_q;
  assign busy        = (state_q == BURST);
  assign err_overrun = err_q;

endmodule : queue_enq_arbiter

// File: tb/tb_queue_enq_arbiter.sv
// Directed self-checking bench for queue_enq_arbiter (NUM_REQ=4, MAX_BURST=16).
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_queue_enq_arbiter;
  import vta_queue_pkg::*;

  localparam int NR = 4;
  localparam int DW = 128;
  localparam int CW = 8;
  localparam int MB = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] cfg_high_wm;
  logic [1:0]    grant_id;
  logic          busy;
  logic [NR-1:0] err_overrun;
  logic          err_clear;

  int n_cmp = 0;
  int n_err = 0;

  queue_enq_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .CNT_W(CW)) bus ();

  queue_enq_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CNT_W(CW), .MAX_BURST(MB)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .cfg_high_wm (cfg_high_wm),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_overrun (err_overrun),
    .err_clear   (err_clear)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] pat(int p, int k);
    return {32'(p), 32'hC0DE_0000, 32'(k), 32'h5A5A_0000 ^ 32'(k)};
  endfunction

  task automatic idle_in();
    bus.req_valid   = '0;
    bus.req_last    = '0;
    bus.req_bits    = '0;
    bus.q_enq_ready = 1'b0;
    bus.q_count     = '0;
    cfg_high_wm     = '0;
    err_clear       = 1'b0;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    tick(); idle_in(); reset = 1'b0;
    tick(); reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_in();
    bus.req_valid   = 4'b1111;
    bus.q_enq_ready = 1'b1;
    reset = 1'b0;
    tick(); tick(); settle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    n_cmp++; if (err_overrun !== 4'b0) begin n_err++; $display("FAIL reset_err: got %b want 0000", err_overrun); end
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.q_enq_valid !== 1'b0) begin n_err++; $display("FAIL reset_enq_valid: got %b want 0", bus.q_enq_valid); end
    n_cmp++; if (bus.q_enq_bits !== '0) begin n_err++; $display("FAIL reset_enq_bits: got %h want 0", bus.q_enq_bits); end
    tick(); idle_in(); reset = 1'b1;
  endtask

  task automatic test_single_burst();
    tick();
    bus.req_valid = 4'b0001; bus.q_enq_ready = 1'b1; bus.req_bits[0 +: DW] = pat(0, 0);
    settle();
    n_cmp++; if (bus.q_enq_valid !== 1'b0) begin n_err++; $display("FAIL single_idle_valid: got %b want 0", bus.q_enq_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.req_bits[0 +: DW] = pat(0, k);
      bus.req_last[0] = (k == 2);
      settle();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy[%0d]: got %b want 1", k, busy); end
      n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL single_grant[%0d]: got %0d want 0", k, grant_id); end
      n_cmp++; if (bus.q_enq_valid !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d]: got %b want 1", k, bus.q_enq_valid); end
      n_cmp++; if (bus.q_enq_bits !== pat(0, k)) begin n_err++; $display("FAIL single_bits[%0d]: got %h want %h", k, bus.q_enq_bits, pat(0, k)); end
      n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready[%0d]: got %b want 0001", k, bus.req_ready); end
    end
    tick();
    bus.req_valid = '0; bus.req_last = '0;
    settle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_done_busy: got %b want 0", busy); end
    n_cmp++; if (err_overrun !== 4'b0) begin n_err++; $display("FAIL single_err: got %b want 0000", err_overrun); end
    n_cmp++; if (bus.q_enq_bits !== '0) begin n_err++; $display("FAIL single_idle_bits: got %h want 0", bus.q_enq_bits); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL single_grant_hold: got %0d want 0", grant_id); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    do_reset();
    bus.req_valid = 4'b1111; bus.req_last = 4'b1111; bus.q_enq_ready = 1'b1;
    for (int i = 0; i < NR; i++) bus.req_bits[i*DW +: DW] = pat(i, 7);
    for (int n = 0; n < 5; n++) begin
      exp_g = 2'(n % NR);
      settle();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fair_bubble[%0d]: got busy %b want 0", n, busy); end
      tick(); settle();
      n_cmp++; if (grant_id !== exp_g) begin n_err++; $display("FAIL fair_grant[%0d]: got %0d want %0d", n, grant_id, exp_g); end
      n_cmp++; if (bus.req_ready !== (4'b0001 << exp_g)) begin n_err++; $display("FAIL fair_ready[%0d]: got %b want %b", n, bus.req_ready, 4'b0001 << exp_g); end
      n_cmp++; if (bus.q_enq_bits !== pat(exp_g, 7)) begin n_err++; $display("FAIL fair_bits[%0d]: got %h want %h", n, bus.q_enq_bits, pat(exp_g, 7)); end
      tick();
    end
    idle_in();
  endtask

  task automatic test_watermark();
    do_reset();
    cfg_high_wm = 8'd8; bus.q_count = 8'd8;
    bus.req_valid = 4'b0010; bus.q_enq_ready = 1'b1; bus.req_bits[1*DW +: DW] = pat(1, 0);
    tick(); settle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wm_blocked: got busy %b want 0", busy); end
    bus.q_count = 8'd7;
    tick(); settle();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wm_grant_busy: got %b want 1", busy); end
    n_cmp++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL wm_grant_id: got %0d want 1", grant_id); end
    bus.q_count = 8'd8;
    tick();
    bus.req_bits[1*DW +: DW] = pat(1, 1); bus.req_last[1] = 1'b1;
    settle();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wm_mid_busy: got %b want 1", busy); end
    n_cmp++; if (bus.q_enq_bits !== pat(1, 1)) begin n_err++; $display("FAIL wm_mid_bits: got %h want %h", bus.q_enq_bits, pat(1, 1)); end
    tick();
    bus.req_last = '0;
    settle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wm_done: got busy %b want 0", busy); end
    tick(); settle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wm_reblocked: got busy %b want 0", busy); end
    idle_in();
  endtask

  task automatic test_overrun();
    do_reset();
    bus.req_valid = 4'b0100; bus.q_enq_ready = 1'b1;
    for (int k = 1; k <= MB; k++) begin
      tick();
      bus.req_bits[2*DW +: DW] = pat(2, k);
      settle();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ovr_busy[%0d]: got %b want 1", k, busy); end
      n_cmp++; if (bus.q_enq_bits !== pat(2, k)) begin n_err++; $display("FAIL ovr_bits[%0d]: got %h want %h", k, bus.q_enq_bits, pat(2, k)); end
    end
    n_cmp++; if (err_overrun !== 4'b0000) begin n_err++; $display("FAIL ovr_err_early: got %b want 0000", err_overrun); end
    tick();
    bus.req_valid = 4'b1100; bus.req_bits[3*DW +: DW] = pat(3, 0);
    settle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_release: got busy %b want 0", busy); end
    n_cmp++; if (err_overrun !== 4'b0100) begin n_err++; $display("FAIL ovr_err_set: got %b want 0100", err_overrun); end
    tick();
    bus.req_last[3] = 1'b1;
    settle();
    n_cmp++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL ovr_rr_next: got %0d want 3", grant_id); end
    tick();
    bus.req_valid = '0; bus.req_last = '0; err_clear = 1'b1;
    settle();
    n_cmp++; if (err_overrun !== 4'b0100) begin n_err++; $display("FAIL ovr_err_sticky: got %b want 0100", err_overrun); end
    tick();
    err_clear = 1'b0;
    settle();
    n_cmp++; if (err_overrun !== 4'b0000) begin n_err++; $display("FAIL ovr_err_clear: got %b want 0000", err_overrun); end
    idle_in();
  endtask

  task automatic test_backpressure();
    bit rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit vld [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [DW-1:0] rx [$];
    int s;
    s = 0;
    do_reset();
    bus.req_valid = 4'b0011; bus.q_enq_ready = 1'b1;
    bus.req_bits[1*DW +: DW] = pat(9, 9);
    for (int c = 0; c < 6; c++) begin
      tick();
      bus.q_enq_ready = rdy[c];
      bus.req_valid[0] = vld[c];
      bus.req_bits[0 +: DW] = pat(0, s);
      bus.req_last[0] = (s == 2);
      settle();
      n_cmp++; if (bus.q_enq_valid !== vld[c]) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want %b", c, bus.q_enq_valid, vld[c]); end
      n_cmp++; if (bus.req_ready !== {3'b000, rdy[c]}) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want %b", c, bus.req_ready, {3'b000, rdy[c]}); end
      if (bus.q_enq_valid === 1'b1 && bus.q_enq_ready === 1'b1) rx.push_back(bus.q_enq_bits);
      if (vld[c] && rdy[c]) s++;
    end
    tick();
    bus.req_valid = '0; bus.req_last = '0;
    settle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_done: got busy %b want 0", busy); end
    n_cmp++; if (rx.size() != 3) begin n_err++; $display("FAIL bp_beat_count: got %0d want 3", rx.size()); end
    for (int i = 0; i < 3 && i < rx.size(); i++) begin
      n_cmp++; if (rx[i] !== pat(0, i)) begin n_err++; $display("FAIL bp_order[%0d]: got %h want %h", i, rx[i], pat(0, i)); end
    end
    idle_in();
  endtask

  // Relies on rr_ptr=1 left by test_backpressure (producer 0 released).
  task automatic test_async_reset();
    tick();
    bus.req_valid = 4'b0100; bus.q_enq_ready = 1'b1; bus.req_bits[2*DW +: DW] = pat(2, 0);
    tick(); settle();
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL ar_grant: got %0d want 2", grant_id); end
    tick();
    bus.req_bits[2*DW +: DW] = pat(2, 1);
    settle();
    n_cmp++; if (bus.q_enq_bits !== pat(2, 1)) begin n_err++; $display("FAIL ar_beat2: got %h want %h", bus.q_enq_bits, pat(2, 1)); end
    #2; reset = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_busy: got %b want 0", busy); end
    n_cmp++; if (bus.q_enq_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b want 0", bus.q_enq_valid); end
    n_cmp++; if (bus.q_enq_bits !== '0) begin n_err++; $display("FAIL ar_bits: got %h want 0", bus.q_enq_bits); end
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL ar_ready: got %b want 0000", bus.req_ready); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL ar_grant_rst: got %0d want 0", grant_id); end
    tick();
    reset = 1'b1; bus.req_valid = 4'b0011;
    bus.req_bits[0 +: DW] = pat(0, 5); bus.req_bits[1*DW +: DW] = pat(1, 5);
    tick(); settle();
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL ar_rr_restart: got %0d want 0", grant_id); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ar_regrant_busy: got %b want 1", busy); end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_single_burst();
    test_fairness();
    test_watermark();
    test_overrun();
    test_backpressure();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_queue_enq_arbiter
